// File: rtl/popcount_accum.sv
// popcount_accum: two-stage per-frame ones counter with wrap-around or saturating accumulation
module popcount_accum #(
  parameter int N     = 5,
  parameter int ACC_W = 8,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);
  localparam int CW = $clog2(N + 1);
  localparam int AW = ACC_W + 1;
  typedef enum logic {ACCUM, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, s1_cnt;
  logic s1_v, s1_last, hold, hold_n, ovf, fire, hs;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0] sum;
  assign fire = in_valid & in_ready;
  assign hs = out_valid & out_ready;
  assign sum = {1'b0, acc} + AW'(s1_cnt);
  assign hold_n = hs ? 1'b0 : (fire & in_last) ? 1'b1 : hold;
  assign out_valid = state == DONE;
  assign out_sum = out_valid ? acc : '0;
  assign out_ovf = out_valid & ovf;
  // count the ones of the incoming beat
  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) cnt = cnt + CW'(in_data[i]);
  end
  // stage 1: register the beat count and its frame-end flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1_last <= 1'b0;
      s1_cnt <= '0;
    end else begin
      s1_v <= fire;
      s1_last <= fire & in_last;
      s1_cnt <= fire ? cnt : '0;
    end
  end
  // frame state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else state <= state_n;
  end
  // frame ends when its last beat is added; result leaves on handshake
  always_comb begin
    state_n = state;
    state_n = (state == DONE) ? (out_ready ? ACCUM : DONE) : ((s1_v & s1_last) ? DONE : ACCUM);
  end
  // stage 2: accumulate with sticky overflow, clearing once the result is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (hs) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (s1_v) begin
      ovf <= ovf | sum[ACC_W];
      acc <= ((SAT != 0) && (ovf || sum[ACC_W])) ? '1 : sum[ACC_W-1:0];
    end
  end
  // input is closed from the last beat of a frame until its result is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      hold <= hold_n;
      in_ready <= ~hold_n;
    end
  end
endmodule
